pbit_sweep_scheduler: RTL and testbench
=======================================

Name: pbit_sweep_scheduler

Overview:
- Sequential Gibbs-sampling controller for a network of p-bit gate activation blocks (COPY/NOT/AND/OR/HA/FA fabric).
- Owns the node-state register vector that feeds the combinational gate network.
- Visits nodes round-robin, samples each node's 4-bit signed activation against a pseudo-random threshold, and writes the new node bit.
- Supports clamped (pinned) nodes, a programmable sweep count and a step-wise inverse-temperature (beta) annealing schedule.

Parameters:
- N_NODES, 5, number of p-bit nodes (2..32)
- ACT_W, 4, activation width, signed
- RND_W, 8, comparison/random width, signed
- SETTLE, 1, wait cycles between a node write and the next sample (0..15)
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; accepted only in IDLE
- n_sweeps  in  16  full sweeps per run; latched on accept
- beta_shift_init  in  3  initial beta left-shift; latched on accept
- anneal_every  in  8  sweeps per beta increment, 0 = no annealing; latched on accept
- clamp_en  in  N_NODES  per-node clamp enable; live, not latched
- clamp_val  in  N_NODES  value forced on clamped nodes; live
- act_flat  in  N_NODES*ACT_W  activations; node i at bits [i*ACT_W +: ACT_W]
- nodes  out  N_NODES  registered node states
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse at end of run
- sweep_cnt  out  16  completed sweeps in current/last run
- upd_idx  out  $clog2(N_NODES)  node currently scheduled
- beta_shift  out  3  current beta shift

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low on rst_n. Reset forces:
  - state=IDLE, nodes=0, busy=0, done=0
  - sweep_cnt=0, upd_idx=0, beta_shift=0
  - LFSR=LFSR_SEED, settle and anneal counters=0
- Mid-run reset: identical to the above. No partial run is resumed.
- FSM states: IDLE, SETTLE, UPDATE, DONE.
- IDLE:
  - start=1 latches the run inputs.
  - Clears sweep_cnt, upd_idx and the anneal counter; loads beta_shift=beta_shift_init.
  - Next state: DONE if n_sweeps==0, otherwise SETTLE (or UPDATE if SETTLE==0).
- SETTLE: waits SETTLE cycles, then goes to UPDATE.
- UPDATE (one cycle):
  - a = act_flat slice for upd_idx, sign-extended to RND_W.
  - s = a<<beta_shift, saturated to [-2^(RND_W-1), 2^(RND_W-1)-1].
  - r = LFSR[RND_W-1:0] taken as signed.
  - nodes[upd_idx] <= (s > r).
  - A clamped upd_idx is a no-op slot with identical timing.
- After UPDATE:
  - If upd_idx<N_NODES-1: upd_idx++ and return to SETTLE/UPDATE.
  - Otherwise: upd_idx=0 and sweep_cnt++. If the new sweep_cnt==n_sweeps, go to DONE.
  - Otherwise, if anneal_every!=0, the anneal counter increments; on reaching anneal_every it clears and beta_shift increments, saturating at 7.
- DONE: done=1 for exactly one cycle, then IDLE. sweep_cnt holds until the next accept.
- Latency: with start accepted at edge k, done is high in cycle k + n_sweeps*N_NODES*(SETTLE+1) + 1 (the cycle after the final UPDATE). For n_sweeps=0, done is high in cycle k+1.
- Clamping: every cycle in every state, clamped bits are written with clamp_val. This overrides updates and applies in IDLE too. Reset still wins.
- LFSR: 16-bit Galois, mask 16'hB400, shift right. Advances every cycle while busy; holds in IDLE.
- start while busy is ignored. Run inputs that change while busy have no effect.
- sweep_cnt wraps naturally; n_sweeps=16'hFFFF is legal.

Decomposition:
- Shared include pbit_defs.vh holds:
  - ACT_W default
  - FSM state encodings
  - LFSR mask and default seed
  - saturating-shift function
- Sub-module pbit_lfsr16 (clk, rst_n, en, seed, q[15:0]) is reused by future samplers.
- Sign-extension, compare and the FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with start=1 → nodes=0, busy=0, done=0, sweep_cnt=0, upd_idx=0, beta_shift=0. Assert rst_n mid-run (sweep 2) → the same values within the same cycle, asynchronously.
- Zero sweeps: start, n_sweeps=0 → busy high 1 cycle, done in cycle k+1, nodes unchanged, LFSR advanced once.
- Deterministic saturation (N_NODES=5, SETTLE=1), n_sweeps=4, beta_shift_init=7, anneal_every=0:
  - All act=-8 → nodes=5'b00000, done at k+41, sweep_cnt=4.
  - All act=+7 → nodes match the bench LFSR model bit-exactly.
- Clamping: clamp_en=5'b00101, clamp_val=5'b00100, all act=-8 → nodes[2]=1 and nodes[0]=0 every cycle from the first edge, others 0, upd_idx still visits 0..4.
- Annealing: beta_shift_init=1, anneal_every=2, n_sweeps=10 → beta_shift increments after sweeps 2,4,6,8 and equals 5 at done. With init=6, anneal_every=1 → saturates at 7.
- Statistics and protocol:
  - act=0, beta_shift=0, 1000 sweeps → fraction of 1s in [0.45,0.55].
  - start pulsed while busy → no restart, done timing unchanged.

Source files
------------

// File: rtl/pbit_sweep_scheduler_pkg.sv
// Shared definitions for the p-bit sampling controllers: state encoding,
// LFSR constants and the saturating left shift used to scale activations.
package pbit_sweep_scheduler_pkg;

   localparam int          ACT_W_DEFAULT     = 4;
   localparam logic [15:0] LFSR_MASK         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_UPDATE = 2'd2,
      ST_DONE   = 2'd3
   } sched_state_t;

   // Shift a signed value left and clamp it to the range of a w-bit signed number.
   function automatic logic signed [31:0] sat_shift(input logic signed [31:0] a,
                                                    input logic [2:0]         sh,
                                                    input int                 w);
      logic signed [31:0] shifted;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      shifted = a <<< sh;
      hi      = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo      = -hi - 32'sd1;
      if (shifted > hi) return hi;
      if (shifted < lo) return lo;
      return shifted;
   endfunction

endpackage

// File: rtl/pbit_sweep_scheduler_lfsr16.sv
// 16-bit right-shifting Galois LFSR with a loadable reset seed; the seed
// must be nonzero or the sequence locks up at zero.
module pbit_lfsr16
   import pbit_sweep_scheduler_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   // Advance one step per enabled cycle, feeding the output bit back through the mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= seed;
      end else if (en) begin
         q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
      end
   end

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Sequential Gibbs sampler for a p-bit gate network: visits nodes
// round-robin, compares each scaled activation against a pseudo-random
// threshold, and anneals the inverse temperature between sweeps.
module pbit_sweep_scheduler
   import pbit_sweep_scheduler_pkg::*;
#(
   parameter int          N_NODES   = 5,
   parameter int          ACT_W     = ACT_W_DEFAULT,
   parameter int          RND_W     = 8,
   parameter int          SETTLE    = 1,
   parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [15:0]                n_sweeps,
   input  logic [2:0]                 beta_shift_init,
   input  logic [7:0]                 anneal_every,
   input  logic [N_NODES-1:0]         clamp_en,
   input  logic [N_NODES-1:0]         clamp_val,
   input  logic [N_NODES*ACT_W-1:0]   act_flat,
   output logic [N_NODES-1:0]         nodes,
   output logic                       busy,
   output logic                       done,
   output logic [15:0]                sweep_cnt,
   output logic [$clog2(N_NODES)-1:0] upd_idx,
   output logic [2:0]                 beta_shift
);

   localparam int                   IDX_W       = $clog2(N_NODES);
   localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_NODES - 1);
   localparam logic [3:0]           SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

   sched_state_t              state;
   sched_state_t              state_nxt;
   logic [15:0]               n_sweeps_q;
   logic [7:0]                anneal_every_q;
   logic [7:0]                anneal_cnt;
   logic [3:0]                settle_cnt;
   logic [15:0]               lfsr_q;
   logic                      unused_lfsr;
   logic signed [ACT_W-1:0]   act_sel;
   logic signed [31:0]        act_scaled;
   logic signed [RND_W-1:0]   rnd_val;
   logic signed [31:0]        rnd_ext;
   logic                      sample_bit;
   logic                      last_node;
   logic [15:0]               sweep_inc;
   logic                      run_done;
   logic [N_NODES-1:0]        nodes_upd;

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   pbit_lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   // Only the low RND_W bits of the LFSR form the threshold; the rest just keep the sequence long.
   assign unused_lfsr = ^lfsr_q;

   assign act_sel    = act_flat[int'(upd_idx) * ACT_W +: ACT_W];
   assign act_scaled = sat_shift(32'(act_sel), beta_shift, RND_W);
   assign rnd_val    = lfsr_q[RND_W-1:0];
   assign rnd_ext    = 32'(rnd_val);
   assign sample_bit = (act_scaled > rnd_ext);
   assign last_node  = (upd_idx == LAST_IDX);
   assign sweep_inc  = sweep_cnt + 16'd1;
   assign run_done   = (sweep_inc == n_sweeps_q);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: settle between node writes, finish after the last node of the last sweep.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               if (n_sweeps == 16'd0) state_nxt = ST_DONE;
               else if (SETTLE == 0)  state_nxt = ST_UPDATE;
               else                   state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state_nxt = ST_UPDATE;
         end
         ST_UPDATE: begin
            if (last_node && run_done) state_nxt = ST_DONE;
            else if (SETTLE == 0)      state_nxt = ST_UPDATE;
            else                       state_nxt = ST_SETTLE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Run bookkeeping: latch the run request, step the node index, count sweeps and anneal beta.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_sweeps_q     <= 16'd0;
         anneal_every_q <= 8'd0;
         anneal_cnt     <= 8'd0;
         settle_cnt     <= 4'd0;
         sweep_cnt      <= 16'd0;
         upd_idx        <= '0;
         beta_shift     <= 3'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  n_sweeps_q     <= n_sweeps;
                  anneal_every_q <= anneal_every;
                  anneal_cnt     <= 8'd0;
                  sweep_cnt      <= 16'd0;
                  upd_idx        <= '0;
                  beta_shift     <= beta_shift_init;
               end
            end
            ST_SETTLE: begin
               settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
            end
            ST_UPDATE: begin
               if (!last_node) begin
                  upd_idx <= upd_idx + IDX_W'(1);
               end else begin
                  upd_idx   <= '0;
                  sweep_cnt <= sweep_inc;
                  if (!run_done && anneal_every_q != 8'd0) begin
                     if (anneal_cnt + 8'd1 == anneal_every_q) begin
                        anneal_cnt <= 8'd0;
                        if (beta_shift != 3'd7) beta_shift <= beta_shift + 3'd1;
                     end else begin
                        anneal_cnt <= anneal_cnt + 8'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Candidate node vector: only the scheduled node changes, and only in an update slot.
   always_comb begin
      nodes_upd = nodes;
      if (state == ST_UPDATE) nodes_upd[upd_idx] = sample_bit;
   end

   // Node register; pinned nodes take their clamp value every cycle regardless of state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) nodes <= '0;
      else        nodes <= (nodes_upd & ~clamp_en) | (clamp_val & clamp_en);
   end

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Scoreboard bench for pbit_sweep_scheduler: each issued run pushes its
// predicted outcome, and a monitor checks it when done pulses.
module tb_pbit_sweep_scheduler;

   localparam int          N    = 5;
   localparam int          AW   = 4;
   localparam int          S    = 1;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [15:0]   n_sweeps;
   logic [2:0]    beta_shift_init;
   logic [7:0]    anneal_every;
   logic [N-1:0]  clamp_en;
   logic [N-1:0]  clamp_val;
   logic [N*AW-1:0] act_flat;
   logic [N-1:0]  nodes;
   logic          busy;
   logic          done;
   logic [15:0]   sweep_cnt;
   logic [2:0]    upd_idx;
   logic [2:0]    beta_shift;

   pbit_sweep_scheduler #(
      .N_NODES   (N),
      .ACT_W     (AW),
      .RND_W     (8),
      .SETTLE    (S),
      .LFSR_SEED (SEED)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .n_sweeps        (n_sweeps),
      .beta_shift_init (beta_shift_init),
      .anneal_every    (anneal_every),
      .clamp_en        (clamp_en),
      .clamp_val       (clamp_val),
      .act_flat        (act_flat),
      .nodes           (nodes),
      .busy            (busy),
      .done            (done),
      .sweep_cnt       (sweep_cnt),
      .upd_idx         (upd_idx),
      .beta_shift      (beta_shift)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          acc;
      int          lat;
      logic [N-1:0] nodes;
      logic [15:0] sweeps;
      logic [2:0]  beta;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_vec  = 0;
   int          n_fail = 0;
   logic [15:0] m_lfsr;
   logic [N-1:0] m_nodes;
   int          clamp_bad;
   logic [7:0]  idx_mask;
   int          ones;
   int          samples;

   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      logic [15:0] nx;
      nx = v >> 1;
      if (v[0]) nx = nx ^ 16'hB400;
      return nx;
   endfunction

   // Node fires when its activation times 2^beta, clipped to a signed byte, beats the threshold byte.
   function automatic logic sampleBit(input int act, input int beta, input logic [15:0] l);
      int s;
      int r;
      s = act * (1 << beta);
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      r = int'(l[7:0]);
      if (r > 127) r = r - 256;
      return (s > r);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Issue one run and push the reference model's prediction for it.
   task automatic applyStimulus(input logic [N*AW-1:0] actv, input logic [N-1:0] ce,
                                input logic [N-1:0] cv, input logic [15:0] n,
                                input logic [2:0] binit, input logic [7:0] ae);
      exp_t              e;
      int                beta;
      logic signed [3:0] a4;
      @(negedge clk);
      act_flat        = actv;
      clamp_en        = ce;
      clamp_val       = cv;
      n_sweeps        = n;
      beta_shift_init = binit;
      anneal_every    = ae;
      start           = 1'b1;
      m_nodes = (m_nodes & ~ce) | (cv & ce);
      for (int w = 0; w < int'(n); w++) begin
         beta = (ae == 8'd0) ? int'(binit) : int'(binit) + w / int'(ae);
         if (beta > 7) beta = 7;
         for (int i = 0; i < N; i++) begin
            repeat (S) m_lfsr = lfsrStep(m_lfsr);
            if (!ce[i]) begin
               a4 = actv[i*AW +: AW];
               m_nodes[i] = sampleBit(int'(a4), beta, m_lfsr);
            end
            m_lfsr = lfsrStep(m_lfsr);
         end
      end
      m_lfsr   = lfsrStep(m_lfsr);
      e.lat    = int'(n) * N * (S + 1);
      e.nodes  = m_nodes;
      e.sweeps = n;
      if (n == 16'd0 || ae == 8'd0) begin
         e.beta = binit;
      end else begin
         beta = int'(binit) + (int'(n) - 1) / int'(ae);
         if (beta > 7) beta = 7;
         e.beta = 3'(beta);
      end
      @(posedge clk);
      #1;
      e.acc = cyc;
      sb.push_back(e);
      start = 1'b0;
   endtask

   // Follow a run until busy drops, collecting clamp, index and occupancy observations.
   task automatic waitIdle(input int budget);
      int c;
      c = 0; clamp_bad = 0; idx_mask = 8'd0; ones = 0; samples = 0;
      @(negedge clk);
      while (busy === 1'b1) begin
         samples++;
         if (((nodes ^ clamp_val) & clamp_en) != '0) clamp_bad++;
         idx_mask[upd_idx] = 1'b1;
         ones += $countones(nodes);
         c++;
         if (c > budget) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL run_timeout: still busy after %0d cycles, expected idle", c);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_nodes"},      32'(nodes),      32'd0);
      checkOutput({tag, "_busy"},       32'(busy),       32'd0);
      checkOutput({tag, "_done"},       32'(done),       32'd0);
      checkOutput({tag, "_sweep_cnt"},  32'(sweep_cnt),  32'd0);
      checkOutput({tag, "_upd_idx"},    32'(upd_idx),    32'd0);
      checkOutput({tag, "_beta_shift"}, 32'(beta_shift), 32'd0);
   endtask

   // Monitor: every done pulse retires the oldest prediction.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected no pending run", cyc);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("done_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            checkOutput("final_nodes",  32'(nodes),           32'(mon_e.nodes));
            checkOutput("sweep_cnt",    32'(sweep_cnt),       32'(mon_e.sweeps));
            checkOutput("beta_at_done", 32'(beta_shift),      32'(mon_e.beta));
         end
      end
   end

   initial begin
      logic [N*AW-1:0] ra;
      logic [N-1:0]    rce;
      logic [N-1:0]    rcv;
      logic            frac_ok;

      rst_n           = 1'b0;
      start           = 1'b1;
      n_sweeps        = 16'd5;
      beta_shift_init = 3'd5;
      anneal_every    = 8'd3;
      act_flat        = 20'h7F3A1;
      clamp_en        = '0;
      clamp_val       = '0;
      m_lfsr          = SEED;
      m_nodes         = '0;
      repeat (3) @(negedge clk);
      checkResetState("reset");

      start     = 1'b0;
      clamp_en  = 5'b00101;
      clamp_val = 5'b00100;
      act_flat  = 20'h88888;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("clamp_first_edge", 32'(nodes), 32'h04);
      m_nodes = 5'b00100;

      applyStimulus(20'h88888, 5'b00101, 5'b00100, 16'd4, 3'd7, 8'd0);
      waitIdle(2000);
      checkOutput("clamp_held_every_cycle", 32'(clamp_bad), 32'd0);
      checkOutput("clamp_run_idx_visits",   32'(idx_mask),  32'h1F);
      checkOutput("clamp_run_nodes",        32'(nodes),     32'h04);

      applyStimulus(20'h88888, 5'b00000, 5'b00000, 16'd4, 3'd7, 8'd0);
      waitIdle(2000);
      checkOutput("neg_sat_nodes", 32'(nodes), 32'h00);

      applyStimulus(20'h77777, 5'b00000, 5'b00000, 16'd4, 3'd7, 8'd0);
      waitIdle(2000);

      applyStimulus(20'($urandom), 5'b00000, 5'b00000, 16'd0, 3'd2, 8'd1);
      waitIdle(100);
      checkOutput("zero_sweep_busy_cycles", 32'(samples), 32'd1);

      applyStimulus(20'($urandom), 5'b00000, 5'b00000, 16'd10, 3'd1, 8'd2);
      waitIdle(2000);
      checkOutput("anneal_beta_held", 32'(beta_shift), 32'd5);

      applyStimulus(20'($urandom), 5'b00000, 5'b00000, 16'd5, 3'd6, 8'd1);
      waitIdle(2000);

      applyStimulus(20'($urandom), 5'b00000, 5'b00000, 16'd3, 3'd2, 8'd1);
      repeat (6) @(negedge clk);
      start           = 1'b1;
      n_sweeps        = 16'd0;
      beta_shift_init = 3'd0;
      anneal_every    = 8'd0;
      @(negedge clk);
      start = 1'b0;
      waitIdle(2000);
      @(negedge clk);
      checkOutput("no_restart_after_busy_start", 32'(busy), 32'd0);

      applyStimulus(20'h00000, 5'b00000, 5'b00000, 16'd1000, 3'd0, 8'd0);
      waitIdle(20000);
      frac_ok = (ones * 100 >= 45 * samples * N) && (ones * 100 <= 55 * samples * N);
      if (!frac_ok)
         $display("[TB] ones=%0d over %0d node-cycles", ones, samples * N);
      checkOutput("ones_fraction_in_range", 32'(frac_ok), 32'd1);

      for (int t = 0; t < 20; t++) begin
         ra  = 20'($urandom);
         rce = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
         rcv = 5'($urandom);
         applyStimulus(ra, rce, rcv, 16'($urandom_range(0, 4)),
                       3'($urandom_range(0, 7)), 8'($urandom_range(0, 3)));
         waitIdle(2000);
      end

      applyStimulus(20'($urandom), 5'b00000, 5'b00000, 16'd4, 3'd3, 8'd0);
      repeat (22) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetState("midrun_reset");
      sb.delete();
      m_lfsr  = SEED;
      m_nodes = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(20'($urandom), 5'b00000, 5'b00000, 16'd3, 3'd4, 8'd1);
      waitIdle(2000);

      repeat (2) @(negedge clk);
      checkOutput("pending_runs_at_end", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
